pipe_cla_add: RTL

- Parametrised, pipelined carry-lookahead adder for the ALU datapath. Successor to the fixed 4-bit CLA slice.
- WIDTH bits are built from 4-bit lookahead groups. The groups are split across STAGES register stages, and the carry is registered at each stage boundary.
- Valid/ready handshake on input and output. Supports back-pressure from the consumer.
- Produces sum, carry-out, signed overflow and zero flag, all aligned to the result.

---
 rtl/alu_defs.sv | 18 +
 rtl/cla_group4.sv | 32 +++
 rtl/pipe_cla_add.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_defs.sv
// Shared ALU datapath definitions.
//   CLA_GROUP_W : width of one carry-lookahead group
//   group_count : number of lookahead groups for a given operand width
//   FLAG_*      : bit positions inside the registered result flag vector
package alu_defs;

  localparam int unsigned CLA_GROUP_W = 4;

  localparam int unsigned FLAG_CO   = 0;
  localparam int unsigned FLAG_OFL  = 1;
  localparam int unsigned FLAG_ZERO = 2;
  localparam int unsigned FLAG_W    = 3;

  function automatic int unsigned group_count(input int unsigned width);
    return width / CLA_GROUP_W;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead slice.
// Ports:
//   a, b : 4-bit operand slices
//   ci   : carry into bit 0 of the slice
//   s    : 4-bit sum
//   p, g : group propagate / generate for the second-level lookahead
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       p,
  output logic       g
);

  logic [3:0] pb;
  logic [3:0] gb;
  logic [3:0] c;

  always_comb begin
    pb   = a ^ b;
    gb   = a & b;
    c[0] = ci;
    c[1] = gb[0] | (pb[0] & ci);
    c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & ci);
    c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0]) | (pb[2] & pb[1] & pb[0] & ci);
    s    = pb ^ c;
    p    = &pb;
    g    = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1]) | (pb[3] & pb[2] & pb[1] & gb[0]);
  end

endmodule

// File: rtl/pipe_cla_add.sv
// Pipelined carry-lookahead adder with valid/ready handshake.
// WIDTH bits are split into 4-bit groups; STAGES slices of groups are evaluated one per
// cycle, with the inter-slice carry, the not-yet-used operand bits and the finished low sum
// bits registered at every slice boundary. The final slice feeds one output register that
// holds Sum and the CO/Ofl/Zero flags together.
// Optional: define PIPE_CLA_SUB_EN to add the Sub input (Sum = A - B, CI ignored).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake (in_ready = pipeline may advance)
//   A, B, CI            : operands and carry-in
//   Sub                 : subtract select (PIPE_CLA_SUB_EN only)
//   out_valid, out_ready: output handshake
//   Sum, CO, Ofl, Zero  : result and flags
module pipe_cla_add
  import alu_defs::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
`ifdef PIPE_CLA_SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             Ofl,
  output logic             Zero
);

  localparam int unsigned NumGroups = group_count(WIDTH);
  localparam int unsigned Gps       = NumGroups / STAGES;
  localparam int unsigned Sw        = Gps * CLA_GROUP_W;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Every register moves together; a stalled output freezes the whole pipe, bubbles included.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

`ifdef PIPE_CLA_SUB_EN
  assign b_eff   = Sub ? ~B : B;
  assign cin_eff = Sub ? 1'b1 : CI;
`else
  assign b_eff   = B;
  assign cin_eff = CI;
`endif

  // Stage k consumes the low Sw bits of the operand bits still pending.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned RemW  = WIDTH - k * Sw;
    localparam int unsigned DoneW = (k + 1) * Sw;

    logic [RemW-1:0]  a_in;
    logic [RemW-1:0]  b_in;
    logic             cin;
    logic             v_in;
    logic [Gps-1:0]   gp;
    logic [Gps-1:0]   gg;
    logic [Gps:0]     gc;
    logic [Sw-1:0]    s_slice;
    logic [DoneW-1:0] s_acc;

    if (k == 0) begin : g_head
      assign a_in  = A;
      assign b_in  = b_eff;
      assign cin   = cin_eff;
      assign v_in  = in_valid;
      assign s_acc = s_slice;
    end else begin : g_tail
      assign a_in  = g_bnd[k-1].a_q;
      assign b_in  = g_bnd[k-1].b_q;
      assign cin   = g_bnd[k-1].c_q;
      assign v_in  = g_bnd[k-1].v_q;
      assign s_acc = {s_slice, g_bnd[k-1].s_q};
    end

    for (genvar j = 0; j < Gps; j++) begin : g_grp
      cla_group4 u_grp (
        .a  (a_in[j*CLA_GROUP_W +: CLA_GROUP_W]),
        .b  (b_in[j*CLA_GROUP_W +: CLA_GROUP_W]),
        .ci (gc[j]),
        .s  (s_slice[j*CLA_GROUP_W +: CLA_GROUP_W]),
        .p  (gp[j]),
        .g  (gg[j])
      );
    end

    // Second-level lookahead: each group carry is a flat OR of generate/propagate paths.
    assign gc[0] = cin;
    for (genvar i = 0; i < Gps; i++) begin : g_la
      logic [i+1:0] terms;
      assign terms[0] = cin & (&gp[i:0]);
      for (genvar j = 0; j <= i; j++) begin : g_t
        if (j == i) begin : g_own
          assign terms[j+1] = gg[j];
        end else begin : g_prop
          assign terms[j+1] = gg[j] & (&gp[i:j+1]);
        end
      end
      assign gc[i+1] = |terms;
    end
  end

  // Boundary registers between stage k and stage k+1.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_bnd
    localparam int unsigned RemW  = WIDTH - k * Sw;
    localparam int unsigned HiW   = WIDTH - (k + 1) * Sw;
    localparam int unsigned DoneW = (k + 1) * Sw;

    logic [HiW-1:0]   a_q;
    logic [HiW-1:0]   b_q;
    logic [DoneW-1:0] s_q;
    logic             c_q;
    logic             v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (advance) begin
        a_q <= g_stg[k].a_in[RemW-1:Sw];
        b_q <= g_stg[k].b_in[RemW-1:Sw];
        s_q <= g_stg[k].s_acc;
        c_q <= g_stg[k].gc[Gps];
        v_q <= g_stg[k].v_in;
      end
    end
  end

  logic [WIDTH-1:0]  sum_fin;
  logic              a_msb;
  logic              b_msb;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] flags_q;
  logic [WIDTH-1:0]  sum_q;
  logic              valid_q;

  assign sum_fin = g_stg[STAGES-1].s_acc;
  assign a_msb   = g_stg[STAGES-1].a_in[Sw-1];
  assign b_msb   = g_stg[STAGES-1].b_in[Sw-1];

  always_comb begin
    flags_d            = '0;
    flags_d[FLAG_CO]   = g_stg[STAGES-1].gc[Gps];
    // b_msb is the effective operand, so subtraction overflow falls out of the same rule.
    flags_d[FLAG_OFL]  = (a_msb == b_msb) && (sum_fin[WIDTH-1] != a_msb);
    flags_d[FLAG_ZERO] = (sum_fin == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      flags_q <= '0;
    end else if (advance) begin
      valid_q <= g_stg[STAGES-1].v_in;
      sum_q   <= sum_fin;
      flags_q <= flags_d;
    end
  end

  assign out_valid = valid_q;
  assign Sum       = sum_q;
  assign CO        = flags_q[FLAG_CO];
  assign Ofl       = flags_q[FLAG_OFL];
  assign Zero      = flags_q[FLAG_ZERO];

endmodule
